// File: rtl/bcd_scan_driver_pkg.sv
// Shared constants for the 4-digit multiplexed BCD display driver.
// Segment patterns are active-low, bit 0 = segment a through bit 6 = segment g.
package bcd_scan_driver_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low 7-segment pattern; purely combinational.
// Codes 10-15 decode to all segments off.
module bcd_to_7seg
  import bcd_scan_driver_pkg::*;
(
  input  logic [3:0] bcd_dat,
  output logic [6:0] seg_dat
);

  always_comb begin
    seg_dat = SEG_BLANK;
    case (bcd_dat)
      4'd0:    seg_dat = SEG_0;
      4'd1:    seg_dat = SEG_1;
      4'd2:    seg_dat = SEG_2;
      4'd3:    seg_dat = SEG_3;
      4'd4:    seg_dat = SEG_4;
      4'd5:    seg_dat = SEG_5;
      4'd6:    seg_dat = SEG_6;
      4'd7:    seg_dat = SEG_7;
      4'd8:    seg_dat = SEG_8;
      4'd9:    seg_dat = SEG_9;
      default: seg_dat = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_scan_driver.sv
// Time-multiplexed 4-digit BCD display driver with tear-free double buffering.
// seg/an/err are registered (one cycle after the state they show); no backpressure.
module bcd_scan_driver
  import bcd_scan_driver_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        err
);

  // GUARD never exceeds CLK_DIV-2, so the prescaler width also holds the guard count.
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] guard_q, guard_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   active_q, active_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          frame_done_q, frame_done_d;
  logic          err_q, err_d;

  logic          tick;
  logic          frame_tick;
  logic [3:0]    cur_dig;
  logic [6:0]    dec_seg;
  logic          guard_on;
  logic          lz_blank;

  bcd_to_7seg u_dec (
    .bcd_dat (cur_dig),
    .seg_dat (dec_seg)
  );

  always_comb begin
    tick       = (presc_q == PW'(CLK_DIV - 1));
    frame_tick = tick && (idx_q == 2'd3);

    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    guard_d = guard_q;
    if (tick)
      guard_d = PW'(GUARD);
    else if (guard_q != '0)
      guard_d = guard_q - PW'(1);

    // Using shadow_d lets a load on the boundary tick reach the display directly.
    shadow_d     = load ? digits_in : shadow_q;
    active_d     = frame_tick ? shadow_d : active_q;
    frame_done_d = frame_tick;

    cur_dig  = active_q[{idx_q, 2'b00} +: 4];
    guard_on = (guard_q != '0);
    lz_blank = blank_lz && (idx_q != 2'd0) && ((active_q >> {idx_q, 2'b00}) == 16'd0);

    an_d  = guard_on ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = (guard_on || lz_blank || (cur_dig > 4'd9)) ? SEG_BLANK : dec_seg;

    err_d = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (active_q[k*4 +: 4] > 4'd9) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      guard_q      <= PW'(GUARD);
      shadow_q     <= 16'd0;
      active_q     <= 16'd0;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'b1111;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      guard_q      <= guard_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Bench for bcd_scan_driver: directed display scenarios plus random traffic,
// every cycle compared against a time-indexed reference model.
module tb_bcd_scan_driver;

  localparam int CLK_DIV = 4;
  localparam int GUARD   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        err;

  always #5 clk = ~clk;

  bcd_scan_driver #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits_in  (digits_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done),
    .err        (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: cycles since reset plus the two digit buffers.
  int          m_t;
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_fd;
  logic        e_err;

  logic [7:0]  seen [4];
  int          tear;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Outputs after the coming edge, derived from the slot position in time.
  task automatic model_edge();
    int pos, slot;
    logic [3:0] d;
    logic gon, blk;
    if (rst) begin
      m_t = 0; m_shadow = 16'd0; m_active = 16'd0;
      e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0; e_err = 1'b0;
    end else begin
      pos  = m_t % CLK_DIV;
      slot = (m_t / CLK_DIV) % 4;
      gon  = (pos < GUARD);
      d    = m_active[slot*4 +: 4];
      blk  = blank_lz && (slot != 0) && ((m_active >> (slot*4)) == 16'd0);
      e_an  = gon ? 4'hF : ~(4'b0001 << slot);
      e_seg = (gon || blk || d > 4'd9) ? 7'h7F : seg_of(d);
      e_err = 1'b0;
      for (int k = 0; k < 4; k++) if (m_active[k*4 +: 4] > 4'd9) e_err = 1'b1;
      e_fd = (pos == CLK_DIV - 1) && (slot == 3);
      if (load) m_shadow = digits_in;
      if (e_fd) m_active = m_shadow;
      m_t++;
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      check_eq("an", {12'd0, an}, {12'd0, e_an});
      check_eq("seg", {9'd0, seg}, {9'd0, e_seg});
      check_eq("frame_done", {15'd0, frame_done}, {15'd0, e_fd});
      check_eq("err", {15'd0, err}, {15'd0, e_err});
      for (int k = 0; k < 4; k++) if (an == ~(4'b0001 << k)) seen[k] = {1'b0, seg};
      if (an != 4'hF && seg != 7'b1111001) tear++;
    end
  endtask

  task automatic clear_seen();
    for (int k = 0; k < 4; k++) seen[k] = 8'hFF;
  endtask

  task automatic wait_fd();
    int k = 0;
    while (frame_done !== 1'b1 && k < 8 * CLK_DIV) begin
      cycle(1);
      k++;
    end
    check_eq("fd_timeout", {15'd0, frame_done}, 16'd1);
  endtask

  // Load a value, let it reach the display, then record one full frame.
  task automatic show_frame(input logic [15:0] v, input logic blz);
    blank_lz = blz;
    digits_in = v; load = 1'b1;
    cycle(1);
    load = 1'b0;
    wait_fd();
    clear_seen();
    cycle(4 * CLK_DIV);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    int r;
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 15);
      if (r < 5)       v[k*4 +: 4] = 4'd0;
      else if (r < 14) v[k*4 +: 4] = 4'($urandom_range(1, 9));
      else             v[k*4 +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  initial begin
    rst = 1'b1; load = 1'b0; digits_in = 16'd0; blank_lz = 1'b0;
    clear_seen();
    tear = 0;

    cycle(2);
    check_eq("rst_an", {12'd0, an}, 16'h000F);
    check_eq("rst_seg", {9'd0, seg}, 16'h007F);
    check_eq("rst_fd", {15'd0, frame_done}, 16'd0);
    check_eq("rst_err", {15'd0, err}, 16'd0);

    rst = 1'b0;
    cycle(GUARD);
    check_eq("guard_an", {12'd0, an}, 16'h000F);
    cycle(1);
    check_eq("post_rst_an", {12'd0, an}, 16'h000E);
    check_eq("post_rst_seg", {9'd0, seg}, {9'd0, 7'b1000000});

    show_frame(16'h1234, 1'b0);
    check_eq("1234_d0", {8'd0, seen[0]}, {9'd0, 7'b0011001});
    check_eq("1234_d3", {8'd0, seen[3]}, {9'd0, 7'b1111001});

    show_frame(16'h0007, 1'b1);
    check_eq("lz7_d3", {8'd0, seen[3]}, 16'h007F);
    check_eq("lz7_d2", {8'd0, seen[2]}, 16'h007F);
    check_eq("lz7_d1", {8'd0, seen[1]}, 16'h007F);
    check_eq("lz7_d0", {8'd0, seen[0]}, {9'd0, 7'b1111000});

    show_frame(16'h0000, 1'b1);
    check_eq("lz0_d0", {8'd0, seen[0]}, {9'd0, 7'b1000000});
    check_eq("lz0_d3", {8'd0, seen[3]}, 16'h007F);
    check_eq("lz0_d1", {8'd0, seen[1]}, 16'h007F);
    check_eq("lz0_err", {15'd0, err}, 16'd0);

    show_frame(16'h00A5, 1'b0);
    check_eq("inv_d1", {8'd0, seen[1]}, 16'h007F);
    check_eq("inv_d0", {8'd0, seen[0]}, {9'd0, 7'b0010010});
    check_eq("inv_err", {15'd0, err}, 16'd1);
    digits_in = 16'h0042; load = 1'b1;
    cycle(1);
    load = 1'b0;
    cycle(2);
    check_eq("inv_err_hold", {15'd0, err}, 16'd1);
    wait_fd();
    cycle(1);
    check_eq("inv_err_clear", {15'd0, err}, 16'd0);

    show_frame(16'h1111, 1'b0);
    tear = 0;
    cycle(CLK_DIV);
    digits_in = 16'h8888; load = 1'b1;
    cycle(1);
    load = 1'b0;
    wait_fd();
    check_eq("no_tear", tear[15:0], 16'd0);
    clear_seen();
    cycle(4 * CLK_DIV);
    for (int k = 0; k < 4; k++) check_eq("eights", {8'd0, seen[k]}, 16'd0);

    // Load exactly on the boundary tick must win over the older shadow value.
    wait_fd();
    cycle(4 * CLK_DIV - 1);
    digits_in = 16'h0009; load = 1'b1;
    cycle(1);
    load = 1'b0;
    clear_seen();
    cycle(4 * CLK_DIV);
    check_eq("bnd_load_d0", {8'd0, seen[0]}, {9'd0, 7'b0010000});

    wait_fd();
    cycle(2 * CLK_DIV + 1);
    rst = 1'b1;
    cycle(1);
    check_eq("mid_rst_an", {12'd0, an}, 16'h000F);
    check_eq("mid_rst_seg", {9'd0, seg}, 16'h007F);
    check_eq("mid_rst_fd", {15'd0, frame_done}, 16'd0);
    rst = 1'b0; blank_lz = 1'b1;
    cycle(GUARD + 1);
    check_eq("rel_an", {12'd0, an}, 16'h000E);
    check_eq("rel_seg", {9'd0, seg}, {9'd0, 7'b1000000});

    for (int i = 0; i < 2000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
      digits_in = rand_digits();
      cycle(1);
    end
    rst = 1'b0; load = 1'b0;
    cycle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
